// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// RV32 datapath / memory side. master = sequencer, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int WORD  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [WORD-1:0]  instr;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel_data;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic             alu_src_imm;
    logic [3:0]       alu_ctrl;
    logic [1:0]       wb_sel;
    logic             halted;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, instr, mem_ready,
        output mem_req, mem_we, mem_sel_data, ir_we, pc_we, reg_we,
               alu_src_imm, alu_ctrl, wb_sel, halted, illegal, bus_err, retired
    );

    modport slave (
        output start, instr, mem_ready,
        input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, reg_we,
               alu_src_imm, alu_ctrl, wb_sel, halted, illegal, bus_err, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: one shared memory port, one ALU, one RF write
// port. Steps LW/SW/ADDI/ADD/LUI/ECALL through FETCH..WB and drives the
// datapath enables. ECALL halts cleanly; anything else halts with illegal.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   FETCH  | instruction read from PC, waiting on mem_ready
//   DECODE | classify instr; ECALL/illegal halt here
//   EXEC   | ALU add (rs1 + imm, or rs1 + rs2 for ADD)
//   MEM    | data access at ALU result, waiting on mem_ready
//   WB     | one-cycle register-file write
//   HALT   | terminal until rst_n
module multicycle_ctrl #(
    parameter int WORD        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req;
    logic              mem_we;
    logic              mem_sel_data;
    logic              reg_we;
    logic              alu_src_imm;
    logic [1:0]        wb_sel;
    logic              halted;
    logic              illegal;
    logic              bus_err;
    logic [CNT_W-1:0]  retired;

    logic [WORD-1:0] ir;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_ecall, is_lui, is_lw, is_sw, is_addi, is_add;
    logic            is_mem_op, is_alu_op, timeout;

    // instr is held stable from DECODE until the next fetch completes, so the
    // decode stays valid through EXEC/MEM/WB without latching an op code.
    assign ir        = bus.instr;
    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign is_ecall  = (ir == WORD'(32'h0000_0073));
    assign is_lui    = (opcode == 7'b0110111);
    assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0);
    assign is_mem_op = is_lw || is_sw;
    assign is_alu_op = is_addi || is_add;
    assign timeout   = (wait_cnt == WAIT_LAST);

    // Sequencer: state, registered strobes for the state being entered,
    // sticky flags, wait counter and retire counter.
    // alu_src_imm stays asserted through MEM and WB because the address and
    // the write-back value are taken straight from the unregistered ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_sel_data <= 1'b0;
            reg_we       <= 1'b0;
            alu_src_imm  <= 1'b0;
            wb_sel       <= 2'b00;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            bus_err      <= 1'b0;
            retired      <= '0;
        end else begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_sel_data <= 1'b0;
            reg_we       <= 1'b0;
            alu_src_imm  <= 1'b0;
            wb_sel       <= 2'b00;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE;
                    end else if (timeout) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    if (is_ecall) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        retired <= retired + CNT_W'(1);
                    end else if (is_lui) begin
                        state       <= WB;
                        reg_we      <= 1'b1;
                        wb_sel      <= 2'b10;
                        alu_src_imm <= 1'b1;
                    end else if (is_mem_op || is_alu_op) begin
                        state       <= EXEC;
                        alu_src_imm <= !is_add;
                    end else begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_mem_op) begin
                        state        <= MEM;
                        mem_req      <= 1'b1;
                        mem_sel_data <= 1'b1;
                        mem_we       <= is_sw;
                        alu_src_imm  <= 1'b1;
                        wait_cnt     <= '0;
                    end else begin
                        state       <= WB;
                        reg_we      <= 1'b1;
                        alu_src_imm <= !is_add;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (is_sw) begin
                            state    <= FETCH;
                            mem_req  <= 1'b1;
                            wait_cnt <= '0;
                            retired  <= retired + CNT_W'(1);
                        end else begin
                            state       <= WB;
                            reg_we      <= 1'b1;
                            wb_sel      <= 2'b01;
                            alu_src_imm <= 1'b1;
                        end
                    end else if (timeout) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        mem_req      <= 1'b1;
                        mem_sel_data <= 1'b1;
                        mem_we       <= is_sw;
                        alu_src_imm  <= 1'b1;
                        wait_cnt     <= wait_cnt + WAIT_W'(1);
                    end
                end
                WB: begin
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    wait_cnt <= '0;
                    retired  <= retired + CNT_W'(1);
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // IR and PC load on the fetch completion cycle itself, so these two
    // follow mem_ready combinationally.
    assign bus.ir_we        = (state == FETCH) && bus.mem_ready;
    assign bus.pc_we        = (state == FETCH) && bus.mem_ready;
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_sel_data = mem_sel_data;
    assign bus.reg_we       = reg_we;
    assign bus.alu_src_imm  = alu_src_imm;
    assign bus.alu_ctrl     = 4'b0000;
    assign bus.wb_sel       = wb_sel;
    assign bus.halted       = halted;
    assign bus.illegal      = illegal;
    assign bus.bus_err      = bus_err;
    assign bus.retired      = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for multicycle_ctrl. Each instruction is
// expanded into per-cycle expected output vectors pushed to a queue; the
// driver pops one entry per cycle, applies its inputs and compares.
module tb_multicycle_ctrl;

    localparam int TO = 16;

    localparam logic [15:0] B_REQ   = 16'h8000;
    localparam logic [15:0] B_WE    = 16'h4000;
    localparam logic [15:0] B_SEL   = 16'h2000;
    localparam logic [15:0] B_IRWE  = 16'h1000;
    localparam logic [15:0] B_PCWE  = 16'h0800;
    localparam logic [15:0] B_REGWE = 16'h0400;
    localparam logic [15:0] B_IMM   = 16'h0200;
    localparam logic [15:0] WB_MEM  = 16'h0080;
    localparam logic [15:0] WB_U    = 16'h0100;
    localparam logic [15:0] B_HLT   = 16'h0040;
    localparam logic [15:0] B_ILL   = 16'h0020;
    localparam logic [15:0] B_BERR  = 16'h0010;

    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_CORE  = 16'hFC7F;
    localparam logic [15:0] M_IMM   = 16'hFE7F;
    localparam logic [15:0] M_WB    = 16'hFDFF;

    localparam int K_ADDI = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_LUI = 4, K_ECALL = 5, K_ILL = 6;

    typedef struct {
        bit          start;
        bit          ready;
        logic [31:0] instr;
        logic [15:0] exp;
        logic [15:0] mask;
        logic [31:0] ret;
        string       tag;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    cyc_t        sb_q[$];
    logic [31:0] exp_ret;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc_n  = 0;

    multicycle_ctrl_if #(.WORD(32), .CNT_W(32)) bus ();

    multicycle_ctrl #(.WORD(32), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pack_out();
        return {bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_we, bus.pc_we,
                bus.reg_we, bus.alu_src_imm, bus.wb_sel, bus.halted, bus.illegal,
                bus.bus_err, bus.alu_ctrl};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic push(input bit st, input bit rdy, input logic [31:0] ins,
                        input logic [15:0] exp, input logic [15:0] mask, input string tag);
        cyc_t c;
        c.start = st;
        c.ready = rdy;
        c.instr = ins;
        c.exp   = exp & mask;
        c.mask  = mask;
        c.ret   = exp_ret;
        c.tag   = tag;
        sb_q.push_back(c);
    endtask

    task automatic gen_halt(input logic [15:0] flags);
        for (int i = 0; i < 4; i++)
            push((i % 2) == 0, (i % 2) == 1, 32'h0, B_HLT | flags, M_CORE, "halt");
    endtask

    task automatic gen_fetch(input logic [31:0] ins, input int fw, output bit to);
        int n;
        n  = (fw >= TO) ? TO : fw;
        to = (fw >= TO);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, ins, B_REQ, M_CORE, "fetch_wait");
        if (!to)
            push(1'b0, 1'b1, ins, B_REQ | B_IRWE | B_PCWE, M_CORE, "fetch_done");
    endtask

    task automatic gen_start();
        push(1'b0, 1'b0, 32'h0, 16'h0, M_ALL, "reset_idle");
        push(1'b1, 1'b1, 32'h0, 16'h0, M_ALL, "idle_start");
    endtask

    task automatic gen_instr(input logic [31:0] ins, input int kind, input int fw, input int mw);
        bit          to;
        int          n;
        logic [15:0] mv;
        gen_fetch(ins, fw, to);
        if (to) begin
            gen_halt(B_BERR);
            return;
        end
        push(1'b0, 1'b1, ins, 16'h0, M_CORE, "decode");
        if (kind == K_ECALL) begin
            exp_ret++;
            gen_halt(16'h0);
            return;
        end
        if (kind == K_ILL) begin
            gen_halt(B_ILL);
            return;
        end
        if (kind == K_LUI) begin
            push(1'b0, 1'b1, ins, B_REGWE | WB_U, M_WB, "wb_lui");
            exp_ret++;
            return;
        end
        push(1'b0, 1'b1, ins, (kind == K_ADD) ? 16'h0 : B_IMM, M_IMM, "exec");
        if (kind == K_LW || kind == K_SW) begin
            mv = B_REQ | B_SEL | ((kind == K_SW) ? B_WE : 16'h0);
            n  = (mw >= TO) ? TO : mw;
            for (int i = 0; i < n; i++)
                push(1'b0, 1'b0, ins, mv, M_CORE, "mem_wait");
            if (mw >= TO) begin
                gen_halt(B_BERR);
                return;
            end
            push(1'b0, 1'b1, ins, mv, M_CORE, "mem_done");
            if (kind == K_SW) begin
                exp_ret++;
                return;
            end
            push(1'b0, 1'b1, ins, B_REGWE | WB_MEM, M_WB, "wb_lw");
        end else if (kind == K_ADDI) begin
            push(1'b0, 1'b1, ins, B_REGWE | B_IMM, M_ALL, "wb_addi");
        end else begin
            push(1'b0, 1'b1, ins, B_REGWE, M_WB, "wb_add");
        end
        exp_ret++;
    endtask

    task automatic run_q();
        cyc_t c;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            @(negedge clk);
            bus.start     = c.start;
            bus.mem_ready = c.ready;
            bus.instr     = c.instr;
            #1;
            check_eq(c.tag, {16'h0, pack_out() & c.mask}, {16'h0, c.exp});
            check_eq({c.tag, "_retired"}, bus.retired, c.ret);
            cyc_n++;
        end
    endtask

    task automatic do_reset();
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instr     = 32'h0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 32'h0;
    endtask

    initial begin
        bit to;
        exp_ret = 32'h0;

        // normal program: ADDI, LW with waits, SW, LUI, ADD after fetch waits,
        // SW completing on the last legal wait cycle, then an illegal SLLI
        do_reset();
        gen_start();
        gen_instr(32'h0050_0093, K_ADDI, 0, 0);
        gen_instr(32'h0000_A203, K_LW,   0, 3);
        gen_instr(32'h0020_A223, K_SW,   0, 0);
        gen_instr(32'h1234_52B7, K_LUI,  0, 0);
        gen_instr(32'h0020_81B3, K_ADD,  2, 0);
        gen_instr(32'h0020_A223, K_SW,   1, TO - 1);
        gen_instr(32'h0000_1093, K_ILL,  0, 0);
        run_q();

        // fetch timeout
        do_reset();
        gen_start();
        gen_instr(32'h0050_0093, K_ADDI, TO, 0);
        run_q();

        // fetch completing on the last wait cycle, then data-side timeout
        do_reset();
        gen_start();
        gen_instr(32'h0050_0093, K_ADDI, TO - 1, 0);
        gen_instr(32'h0000_A203, K_LW,   0, TO);
        run_q();

        // SUB shares ADD's opcode/funct3 but not funct7
        do_reset();
        gen_start();
        gen_instr(32'h4020_81B3, K_ILL, 0, 0);
        run_q();

        // async reset in the middle of a load's MEM wait
        do_reset();
        gen_start();
        gen_instr(32'h0050_0093, K_ADDI, 0, 0);
        gen_fetch(32'h0000_A203, 0, to);
        push(1'b0, 1'b1, 32'h0000_A203, 16'h0, M_CORE, "decode");
        push(1'b0, 1'b1, 32'h0000_A203, B_IMM, M_IMM, "exec");
        push(1'b0, 1'b0, 32'h0000_A203, B_REQ | B_SEL, M_CORE, "mem_wait");
        push(1'b0, 1'b0, 32'h0000_A203, B_REQ | B_SEL, M_CORE, "mem_wait");
        run_q();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("t6_req_before_reset", {31'h0, bus.mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_outputs_in_reset", {16'h0, pack_out()}, 32'h0);
        check_eq("t6_retired_in_reset", bus.retired, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 32'h0;
        gen_start();
        gen_instr(32'h0000_0073, K_ECALL, 0, 0);
        run_q();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
